// File: rtl/lifo_stack_ctl.sv
// Parametrised synchronous LIFO stack with occupancy count, almost-full flag,
// combinational top-of-stack peek, replace-top on push+pop and sticky error flags.
module lifo_stack_ctl #(
    parameter  int WIDTH    = 8,
    parameter  int DEPTH    = 8,
    parameter  int AF_LEVEL = DEPTH - 1,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_err,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [WIDTH-1:0] top,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             overflow,
    output logic             underflow
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    top_idx;
    logic [CW-1:0]    wr_idx;
    logic [CW-1:0]    count_nxt;
    logic             pop_ok;
    logic             push_ok;
    logic             push_drop;
    logic             pop_reject;

    assign count       = count_r;
    assign empty       = (count_r == '0);
    assign full        = (count_r == DEPTH_C);
    assign almost_full = (count_r >= AF_C);
    assign top_idx     = count_r - ONE;
    assign top         = empty ? '0 : mem[top_idx[AW-1:0]];

    // A push is still accepted when full as long as a pop frees the top slot
    // in the same cycle (replace-top); on an empty stack the pop is rejected
    // but the push goes ahead into slot 0.
    always_comb begin
        pop_ok     = pop && !empty;
        pop_reject = pop && empty;
        push_ok    = push && (!full || pop_ok);
        push_drop  = push && !push_ok;
        wr_idx     = pop_ok ? top_idx : count_r;
        count_nxt  = count_r;
        if (push_ok && !pop_ok)
            count_nxt = count_r + ONE;
        else if (pop_ok && !push_ok)
            count_nxt = count_r - ONE;
    end

    // Storage is deliberately not reset; empty gating on top hides stale data.
    always_ff @(posedge clk) begin
        if (rstn && push_ok)
            mem[wr_idx[AW-1:0]] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_r    <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            count_r    <= count_nxt;
            dout_valid <= pop_ok;
            if (pop_ok)
                dout <= mem[top_idx[AW-1:0]];

            // A fresh error in the clearing cycle takes priority over clr_err.
            if (push_drop)
                overflow <= 1'b1;
            else if (clr_err)
                overflow <= 1'b0;

            if (pop_reject)
                underflow <= 1'b1;
            else if (clr_err)
                underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lifo_stack_ctl.sv
// Scoreboard bench for lifo_stack_ctl: a DEPTH=8/AF_LEVEL=7 instance and a
// DEPTH=5 instance, with expected pop data queued at issue and checked on dout_valid.
module tb_lifo_stack_ctl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // DEPTH=8 instance
    logic       rstn8, push8, pop8, clr8;
    logic [7:0] din8;
    logic [7:0] dout8, top8;
    logic [3:0] count8;
    logic       dv8, empty8, full8, af8, ovf8, unf8;

    // DEPTH=5 instance
    logic       rstn5, push5, pop5, clr5;
    logic [7:0] din5;
    logic [7:0] dout5, top5;
    logic [2:0] count5;
    logic       dv5, empty5, full5, af5, ovf5, unf5;

    logic [7:0] exp8_q[$];
    logic [7:0] exp5_q[$];

    lifo_stack_ctl #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(7)) u_dut8 (
        .clk(clk), .rstn(rstn8), .push(push8), .pop(pop8), .din(din8),
        .clr_err(clr8), .dout(dout8), .dout_valid(dv8), .top(top8),
        .count(count8), .empty(empty8), .full(full8), .almost_full(af8),
        .overflow(ovf8), .underflow(unf8)
    );

    lifo_stack_ctl #(.WIDTH(8), .DEPTH(5)) u_dut5 (
        .clk(clk), .rstn(rstn5), .push(push5), .pop(pop5), .din(din5),
        .clr_err(clr5), .dout(dout5), .dout_valid(dv5), .top(top5),
        .count(count5), .empty(empty5), .full(full5), .almost_full(af5),
        .overflow(ovf5), .underflow(unf5)
    );

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle on an instance; outputs are settled when the task returns.
    task automatic apply_stimulus8(input logic r, p, q, c, input logic [7:0] d);
        @(negedge clk);
        rstn8 = r; push8 = p; pop8 = q; clr8 = c; din8 = d;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus5(input logic r, p, q, c, input logic [7:0] d);
        @(negedge clk);
        rstn5 = r; push5 = p; pop5 = q; clr5 = c; din5 = d;
        @(posedge clk);
        #1;
    endtask

    // Monitors: every dout_valid pulse must match the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (dv8) begin
            if (exp8_q.size() == 0)
                check_output("dut8 unexpected dout_valid", 32'(dout8), 32'hDEAD);
            else
                check_output("dut8 popped dout", 32'(dout8), 32'(exp8_q.pop_front()));
        end
        if (dv5) begin
            if (exp5_q.size() == 0)
                check_output("dut5 unexpected dout_valid", 32'(dout5), 32'hDEAD);
            else
                check_output("dut5 popped dout", 32'(dout5), 32'(exp5_q.pop_front()));
        end
    end

    initial begin
        logic [7:0] fill [8];
        rstn8 = 0; push8 = 0; pop8 = 0; clr8 = 0; din8 = 0;
        rstn5 = 0; push5 = 0; pop5 = 0; clr5 = 0; din5 = 0;
        fill = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};

        apply_stimulus8(0, 0, 0, 0, 8'h00);
        apply_stimulus8(0, 0, 0, 0, 8'h00);
        check_output("reset count", 32'(count8), 0);
        check_output("reset empty", 32'(empty8), 1);
        check_output("reset dout", 32'(dout8), 0);
        check_output("reset dout_valid", 32'(dv8), 0);
        check_output("reset flags", {30'd0, ovf8, unf8}, 0);
        check_output("reset top", 32'(top8), 0);

        // Basic LIFO order
        apply_stimulus8(1, 1, 0, 0, 8'h11);
        check_output("top after 1 push", 32'(top8), 32'h11);
        apply_stimulus8(1, 1, 0, 0, 8'h22);
        apply_stimulus8(1, 1, 0, 0, 8'h33);
        check_output("count after 3 pushes", 32'(count8), 3);
        check_output("top after 3 pushes", 32'(top8), 32'h33);
        exp8_q.push_back(8'h33); apply_stimulus8(1, 0, 1, 0, 8'h00);
        exp8_q.push_back(8'h22); apply_stimulus8(1, 0, 1, 0, 8'h00);
        exp8_q.push_back(8'h11); apply_stimulus8(1, 0, 1, 0, 8'h00);
        check_output("dout_valid on last pop", 32'(dv8), 1);
        check_output("empty after pops", 32'(empty8), 1);
        apply_stimulus8(1, 0, 0, 0, 8'h00);
        check_output("dout_valid drops when idle", 32'(dv8), 0);
        check_output("dout holds when idle", 32'(dout8), 32'h11);

        // Fill to full, watch almost_full
        for (int i = 0; i < 8; i++) begin
            apply_stimulus8(1, 1, 0, 0, fill[i]);
            if (i == 5) check_output("almost_full at count 6", 32'(af8), 0);
            if (i == 6) check_output("almost_full at count 7", 32'(af8), 1);
            if (i == 6) check_output("full at count 7", 32'(full8), 0);
        end
        check_output("full at count 8", 32'(full8), 1);
        check_output("count full", 32'(count8), 8);
        apply_stimulus8(1, 1, 0, 0, 8'hFF);
        check_output("count after dropped push", 32'(count8), 8);
        check_output("overflow set", 32'(ovf8), 1);
        check_output("top after dropped push", 32'(top8), 32'h08);
        apply_stimulus8(1, 0, 0, 1, 8'h00);
        check_output("overflow cleared", 32'(ovf8), 0);

        // Replace-top on a full stack
        exp8_q.push_back(8'h08); apply_stimulus8(1, 1, 1, 0, 8'hAB);
        check_output("replace dout_valid", 32'(dv8), 1);
        check_output("replace top", 32'(top8), 32'hAB);
        check_output("replace count", 32'(count8), 8);
        check_output("replace no overflow", 32'(ovf8), 0);

        exp8_q.push_back(8'hAB);
        for (int i = 6; i >= 0; i--) exp8_q.push_back(fill[i]);
        for (int i = 0; i < 8; i++) apply_stimulus8(1, 0, 1, 0, 8'h00);
        check_output("empty after drain", 32'(empty8), 1);

        // Underflow on empty
        apply_stimulus8(1, 0, 1, 0, 8'h00);
        check_output("underflow set", 32'(unf8), 1);
        check_output("underflow dout_valid", 32'(dv8), 0);
        check_output("underflow dout holds", 32'(dout8), 32'h01);
        check_output("underflow count", 32'(count8), 0);
        apply_stimulus8(1, 1, 1, 0, 8'h5A);
        check_output("push+pop empty count", 32'(count8), 1);
        check_output("push+pop empty top", 32'(top8), 32'h5A);
        check_output("push+pop empty underflow", 32'(unf8), 1);
        check_output("push+pop empty dout_valid", 32'(dv8), 0);

        // Error event in the clearing cycle wins
        exp8_q.push_back(8'h5A); apply_stimulus8(1, 0, 1, 0, 8'h00);
        apply_stimulus8(1, 0, 1, 1, 8'h00);
        check_output("underflow beats clr_err", 32'(unf8), 1);
        apply_stimulus8(1, 0, 0, 1, 8'h00);
        check_output("underflow cleared", 32'(unf8), 0);

        // Reset mid-burst with underflow set and count=4
        apply_stimulus8(1, 0, 1, 0, 8'h00);
        for (int i = 0; i < 4; i++) apply_stimulus8(1, 1, 0, 0, fill[i]);
        check_output("count before reset", 32'(count8), 4);
        apply_stimulus8(0, 1, 0, 0, 8'h99);
        check_output("mid reset count", 32'(count8), 0);
        check_output("mid reset empty", 32'(empty8), 1);
        check_output("mid reset dout", 32'(dout8), 0);
        check_output("mid reset flags", {30'd0, ovf8, unf8}, 0);
        check_output("mid reset top", 32'(top8), 0);
        apply_stimulus8(1, 0, 0, 0, 8'h00);

        // DEPTH=5 instance
        apply_stimulus5(0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus5(1, 1, 0, 0, 8'hA1 + 8'(i));
            if (i == 3) check_output("dut5 almost_full at 4", 32'(af5), 1);
        end
        check_output("dut5 full", 32'(full5), 1);
        check_output("dut5 count", 32'(count5), 5);
        apply_stimulus5(1, 1, 0, 0, 8'hA6);
        check_output("dut5 count after drop", 32'(count5), 5);
        check_output("dut5 overflow", 32'(ovf5), 1);
        check_output("dut5 top after drop", 32'(top5), 32'hA5);
        for (int i = 4; i >= 0; i--) begin
            exp5_q.push_back(8'hA1 + 8'(i));
            apply_stimulus5(1, 0, 1, 0, 8'h00);
        end
        check_output("dut5 empty", 32'(empty5), 1);

        apply_stimulus5(1, 0, 0, 0, 8'h00);
        apply_stimulus8(1, 0, 0, 0, 8'h00);
        check_output("dut8 scoreboard drained", exp8_q.size(), 0);
        check_output("dut5 scoreboard drained", exp5_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lifo_stack_ctl.md
Name: lifo_stack_ctl

Overview:
- Parametrised synchronous LIFO stack. Next generation of the team's basic stack.
- Adds the following over the basic stack:
  - correct full/empty at any DEPTH
  - occupancy count and almost-full flag
  - combinational peek of the top entry
  - defined simultaneous push+pop (replace-top)
  - sticky overflow/underflow error flags with clear
- Used as a return-address / context buffer between a control FSM and a datapath.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 8, number of entries (>=2; need not be a power of two).
- AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- CW, $clog2(DEPTH+1), count width (derived, not overridden).

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- rstn, in, 1, synchronous active-low reset.
- push, in, 1, write din onto stack this cycle.
- pop, in, 1, remove top entry this cycle.
- din, in, WIDTH, push data.
- clr_err, in, 1, clears sticky overflow/underflow.
- dout, out, WIDTH, registered popped data.
- dout_valid, out, 1, one-cycle pulse: dout updated by an accepted pop.
- top, out, WIDTH, combinational peek of current top entry; 0 when empty.
- count, out, CW, number of stored entries, 0..DEPTH.
- empty, out, 1, count == 0.
- full, out, 1, count == DEPTH.
- almost_full, out, 1, count >= AF_LEVEL.
- overflow, out, 1, sticky: a push was dropped.
- underflow, out, 1, sticky: a pop was rejected.

Behaviour:

Reset:
- rstn=0 at a clock edge sets count=0, dout=0, dout_valid=0, overflow=0, underflow=0.
- Storage array is not reset. top reads 0 because empty.
- Reset mid-operation discards all contents; push/pop in that cycle are ignored.

State:
- count register; storage mem[0..DEPTH-1].
- Top entry = mem[count-1]. No separate FSM; the operation decode below acts as the state machine.
- empty, full, almost_full and top are combinational from registered count/mem.

Operation decode (per cycle, rstn=1):
- Idle (push=0, pop=0): no change; dout holds; dout_valid=0.
- Push only, not full:
  - mem[count] <= din; count+1.
- Push only, full:
  - write dropped; count unchanged; overflow <= 1.
- Pop only, not empty:
  - dout <= mem[count-1]; dout_valid <= 1; count-1.
  - Popped data appears on dout 1 cycle after the pop edge.
- Pop only, empty:
  - dout holds; dout_valid <= 0; underflow <= 1.
- Push+pop, not empty (including full): replace-top.
  - dout <= old mem[count-1]; dout_valid <= 1.
  - mem[count-1] <= din; count unchanged.
  - No overflow, even when full.
- Push+pop, empty:
  - pop rejected (underflow <= 1, dout_valid <= 0).
  - push executes: mem[0] <= din; count = 1.

Error flags:
- clr_err=1 clears overflow/underflow at the edge.
- A new error event in the same cycle as clr_err wins (flag ends 1).

Arithmetic:
- count never wraps: it saturates logically, because over/underflowing operations are blocked.
- Index arithmetic is CW bits wide, so count==DEPTH is representable for any DEPTH, including powers of two.

Timing:
- Back-to-back push/pop every cycle is supported with no bubbles.
- top reflects a push on the cycle after the push edge.

Test Plan:
- Reset, then push 0x11,0x22,0x33 on consecutive cycles -> count=3, top=0x33; then 3 pops -> dout sequence 0x33,0x22,0x11, each with dout_valid pulse 1 cycle after its pop, empty=1 after the last.
- DEPTH=8, AF_LEVEL=7: push 8 words 0x01..0x08 -> almost_full rises at count=7, full at 8. Then push 0xFF -> count stays 8, overflow=1, top=0x08. Then clr_err -> overflow=0.
- Empty stack: pop -> underflow=1, dout_valid=0, dout holds prior value, count=0. Same cycle push+pop with din=0x5A -> count=1, top=0x5A, underflow=1.
- Full stack, push+pop with din=0xAB -> dout=0x08 with dout_valid=1, top=0xAB, count=8, overflow stays 0.
- DEPTH=5 (non-power-of-two): fill to 5 -> full=1, count=5. A 6th push is dropped. Pop 5 -> empty=1, LIFO order preserved.
- Reset asserted mid-burst with count=4 and push=1 -> next cycle count=0, empty=1, dout=0, flags 0, top=0.
